// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide into HI/LO,
// one iteration per cycle, with MTHI/MTLO writes accepted while idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               is_div, neg_q, neg_r, div_zero;

    logic               signed_in;
    logic [WIDTH-1:0]   abs_a_in, abs_b_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] step_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign signed_in = ~op[0];
    assign abs_a_in  = (signed_in && A[WIDTH-1]) ? -A : A;
    assign abs_b_in  = (signed_in && B[WIDTH-1]) ? -B : B;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CALC;
            S_CALC:  if (count == LAST) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        if (is_div)
            step_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            step_next = {mul_sum, acc[WIDTH-1:1]};
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            acc      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= '0;
                        is_div   <= op[1];
                        neg_q    <= signed_in & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r    <= signed_in & A[WIDTH-1] & op[1];
                        div_zero <= (B == '0);
                        mag_b    <= abs_b_in;
                        // divide never uses mag_a as an addend, so it keeps raw A for the B==0 case
                        mag_a    <= op[1] ? A : abs_a_in;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a_in : abs_b_in)};
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: begin
                    acc <= step_next;
                    if (count != LAST) count <= count + 1'b1;
                end
                S_FIN: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= mag_a;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results come from native SV arithmetic.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sbv, q, r;
        case (o)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sa = a; sbv = b;
                q = sa / sbv; r = sa % sbv;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the following negedge with start low again.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m;
        exp_t e;
        m = model(o, a, b);
        e.hi = m[63:32];
        e.lo = m[31:0];
        scb.push_back(e);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h want=0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h want=0", lo); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul;
        logic [65:0] vec [7] = '{
            {2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF},
            {2'b00, 32'hFFFFFFFD, 32'h00000005},
            {2'b00, 32'h80000000, 32'h80000000},
            {2'b00, 32'h7FFFFFFF, 32'h80000000},
            {2'b01, 32'h12345678, 32'h9ABCDEF0},
            {2'b00, 32'h00000000, 32'hFFFFFFFF},
            {2'b01, 32'h00000001, 32'h80000000}};
        logic [65:0] v;
        exp_t e;
        int cyc, bc;
        for (int i = 0; i < 9; i++) begin
            v = (i < 7) ? vec[i] : {1'b0, 1'(i - 7), 32'($urandom), 32'($urandom)};
            launch(v[65:64], v[63:32], v[31:0]);
            wait_done(cyc, bc);
            n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL mul_latency[%0d] got=%0d want=33", i, cyc); end
            n_checks++; if (bc != 33) begin n_fail++; $display("FAIL mul_busy_cycles[%0d] got=%0d want=33", i, bc); end
            e = scb.pop_front();
            n_checks++;
            if (hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL mul_result[%0d] got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, e.hi, e.lo);
            end
            if (i == 0) begin
                n_checks++;
                if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
                    n_fail++;
                    $display("FAIL multu_max got hi=%h lo=%h want hi=fffffffe lo=00000001", hi, lo);
                end
            end
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse[%0d] got=%b want=0", i, done); end
        end
    endtask

    task automatic test_div;
        logic [65:0] vec [8] = '{
            {2'b10, 32'hFFFFFFF9, 32'h00000002},
            {2'b10, 32'h80000000, 32'hFFFFFFFF},
            {2'b10, 32'h00000007, 32'hFFFFFFFE},
            {2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE},
            {2'b11, 32'h00000064, 32'h00000007},
            {2'b11, 32'hFFFFFFFF, 32'h00000001},
            {2'b11, 32'h00000005, 32'h00000009},
            {2'b11, 32'h80000000, 32'hFFFFFFFF}};
        logic [65:0] v;
        exp_t e;
        int cyc, bc;
        for (int i = 0; i < 11; i++) begin
            v = (i < 8) ? vec[i] : {1'b1, 1'($urandom), 32'($urandom), 32'($urandom_range(1, 32'h0FFFFFFF))};
            launch(v[65:64], v[63:32], v[31:0]);
            wait_done(cyc, bc);
            n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL div_latency[%0d] got=%0d want=33", i, cyc); end
            e = scb.pop_front();
            n_checks++;
            if (hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL div_result[%0d] got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, e.hi, e.lo);
            end
            if (i == 1) begin
                n_checks++;
                if (hi !== 32'h0 || lo !== 32'h80000000) begin
                    n_fail++;
                    $display("FAIL div_minneg got hi=%h lo=%h want hi=00000000 lo=80000000", hi, lo);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero;
        logic [65:0] vec [3] = '{
            {2'b11, 32'h00000007, 32'h00000000},
            {2'b10, 32'hFFFFFFFB, 32'h00000000},
            {2'b10, 32'h00000000, 32'h00000000}};
        logic [65:0] v;
        exp_t e;
        int cyc, bc;
        for (int i = 0; i < 3; i++) begin
            v = vec[i];
            launch(v[65:64], v[63:32], v[31:0]);
            wait_done(cyc, bc);
            n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL divz_latency[%0d] got=%0d want=33", i, cyc); end
            e = scb.pop_front();
            n_checks++;
            if (hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL divz_result[%0d] got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, e.hi, e.lo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy;
        exp_t e;
        int cyc, bc, dones, busys;
        launch(2'b01, 32'h0000FFFF, 32'h00010001);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b11; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL swb_done got=%b want=1", done); end
        e = scb.pop_front();
        n_checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL swb_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
        dones = 0; busys = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busys++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL swb_extra_done got=%0d want=0", dones); end
        n_checks++; if (busys != 0) begin n_fail++; $display("FAIL swb_queued_op busy_cycles got=%0d want=0", busys); end
    endtask

    task automatic test_reset_mid_op;
        int dones, busys;
        launch(2'b11, 32'hFFFFFFF0, 32'h00000003);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b want=0", busy); end
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rmid_hilo got hi=%h lo=%h want 0", hi, lo); end
        @(negedge clk);
        rst = 1'b0;
        scb.delete();
        dones = 0; busys = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busys++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rmid_done got=%0d want=0", dones); end
        n_checks++; if (busys != 0) begin n_fail++; $display("FAIL rmid_resume got=%0d want=0", busys); end
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rmid_partial got hi=%h lo=%h want 0", hi, lo); end
    endtask

    task automatic test_mthi_mtlo;
        exp_t e;
        int cyc, bc;
        hi_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi got=%h want=12345678", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL mthi_lo_kept got=%h want=00000000", lo); end
        lo_we = 1'b1; wdata = 32'h9ABCDEF0;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++; if (lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo got=%h want=9abcdef0", lo); end
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_hi_kept got=%h want=12345678", hi); end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F0F0F;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks++; if (hi !== 32'h0F0F0F0F || lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL mt_both got hi=%h lo=%h want 0f0f0f0f", hi, lo); end
        launch(2'b01, 32'd3, 32'd4);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks++; if (hi !== 32'h0F0F0F0F || lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL mt_busy got hi=%h lo=%h want 0f0f0f0f", hi, lo); end
        wait_done(cyc, bc);
        e = scb.pop_front();
        n_checks++; if (hi !== e.hi || lo !== e.lo) begin n_fail++; $display("FAIL mt_busy_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo); end
        lo_we = 1'b1; wdata = 32'h55555555;
        launch(2'b11, 32'd20, 32'd6);
        lo_we = 1'b0;
        n_checks++; if (lo !== 32'h0000000C) begin n_fail++; $display("FAIL start_wins_lo got=%h want=0000000c", lo); end
        wait_done(cyc, bc);
        e = scb.pop_front();
        n_checks++; if (hi !== e.hi || lo !== e.lo) begin n_fail++; $display("FAIL start_wins_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [65:0] vec [4] = '{
            {2'b00, 32'hFFFFFFFD, 32'h00000005},
            {2'b10, 32'hFFFFFFF9, 32'h00000002},
            {2'b11, 32'h00000007, 32'h00000000},
            {2'b01, 32'hDEADBEEF, 32'h0000CAFE}};
        logic [65:0] v;
        exp_t e;
        int cyc, bc;
        v = vec[0];
        launch(v[65:64], v[63:32], v[31:0]);
        for (int i = 0; i < 4; i++) begin
            wait_done(cyc, bc);
            n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL b2b_latency[%0d] got=%0d want=33", i, cyc); end
            e = scb.pop_front();
            n_checks++;
            if (hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL b2b_result[%0d] got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, e.hi, e.lo);
            end
            if (i < 3) begin
                v = vec[i + 1];
                launch(v[65:64], v[63:32], v[31:0]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_start_while_busy;
        test_reset_mid_op;
        test_mthi_mtlo;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
